// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, then a sign-fix cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] MdOp1,
  input  logic [WIDTH-1:0] MdOp2,
  input  logic [2:0]       MdOp,
  input  logic             MdStart,
  input  logic             MdAbort,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             sa_q, sa_d, sb_q, sb_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] shq_q, shq_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  // rem_q/shq_q hold {partial sum, multiplier} for mult, {remainder, dividend->quotient} for div
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic [2*WIDTH-1:0] prod_mag, prod_fix;
  logic [WIDTH-1:0]   op1_mag, op2_mag;
  logic               op_signed;

  assign op_signed = ~MdOp[0];
  assign op1_mag   = (op_signed && MdOp1[WIDTH-1]) ? -MdOp1 : MdOp1;
  assign op2_mag   = (op_signed && MdOp2[WIDTH-1]) ? -MdOp2 : MdOp2;

  assign mul_sum   = rem_q + (shq_q[0] ? {1'b0, a_q} : '0);
  assign div_shift = {rem_q[WIDTH-1:0], shq_q[WIDTH-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, b_q};
  assign prod_mag  = {rem_q[WIDTH-1:0], shq_q};
  assign prod_fix  = (sa_q ^ sb_q) ? -prod_mag : prod_mag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    shq_d    = shq_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MdStart && !MdAbort) begin
          if (!MdOp[2]) begin
            is_div_d = MdOp[1];
            sa_d     = op_signed & MdOp1[WIDTH-1];
            sb_d     = op_signed & MdOp2[WIDTH-1];
            a_d      = op1_mag;
            b_d      = op2_mag;
            rem_d    = '0;
            shq_d    = MdOp[1] ? op1_mag : op2_mag;
            cnt_d    = '0;
            state_d  = S_RUN;
          end else if (!MdOp[1]) begin
            if (MdOp[0]) lo_d = MdOp1;
            else         hi_d = MdOp1;
          end
        end
      end
      S_RUN: begin
        if (MdAbort) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            if (!div_diff[WIDTH+1]) begin
              rem_d = div_diff[WIDTH:0];
              shq_d = {shq_q[WIDTH-2:0], 1'b1};
            end else begin
              rem_d = div_shift;
              shq_d = {shq_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            rem_d = {1'b0, mul_sum[WIDTH:1]};
            shq_d = {mul_sum[0], shq_q[WIDTH-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!MdAbort) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (b_q == '0) begin
            // divide by zero: all-ones quotient, dividend returned untouched
            lo_d = '1;
            hi_d = sa_q ? -a_q : a_q;
          end else begin
            lo_d = (sa_q ^ sb_q) ? -shq_q : shq_q;
            hi_d = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      shq_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      shq_q    <= shq_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign Busy = (state_q != S_IDLE);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, restart, abort, MTHI/MTLO, reset.
module tb_mult_div_unit;
  logic        clk, rst_n;
  logic [31:0] MdOp1, MdOp2;
  logic [2:0]  MdOp;
  logic        MdStart, MdAbort;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  int n_chk = 0;
  int n_err = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .MdOp1(MdOp1), .MdOp2(MdOp2), .MdOp(MdOp),
    .MdStart(MdStart), .MdAbort(MdAbort), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Launch one op, then watch Busy/Done at each falling edge until both drop.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el,
                        input int exp_bc, input int exp_dc, input int restart_at, input int abort_at);
    int bc = 0;
    int dc = 0;
    @(negedge clk);
    MdOp = op; MdOp1 = a; MdOp2 = b; MdStart = 1'b1;
    @(negedge clk);
    MdStart = 1'b0; MdOp1 = 32'hDEADBEEF; MdOp2 = 32'h0;
    for (int i = 1; i <= 70; i++) begin
      if (Busy) bc++;
      if (Done) dc++;
      if (!Busy && !Done) break;
      if (i == restart_at) begin
        MdStart = 1'b1; MdOp = 3'b001; MdOp1 = 32'h1; MdOp2 = 32'h1;
      end else begin
        MdStart = 1'b0;
      end
      MdAbort = (i == abort_at);
      @(negedge clk);
    end
    MdStart = 1'b0; MdAbort = 1'b0;
    chk({tag, "_busy_cycles"}, 64'(bc), 64'(exp_bc));
    chk({tag, "_done_pulses"}, 64'(dc), 64'(exp_dc));
    chk({tag, "_hi"}, 64'(Hi), 64'(eh));
    chk({tag, "_lo"}, 64'(Lo), 64'(el));
  endtask

  initial begin
    rst_n = 1'b0; MdOp1 = '0; MdOp2 = '0; MdOp = 3'b000; MdStart = 1'b0; MdAbort = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", 64'(Hi), 64'h0);
    chk("rst_lo", 64'(Lo), 64'h0);
    chk("rst_busy", 64'(Busy), 64'h0);
    chk("rst_done", 64'(Done), 64'h0);
    rst_n = 1'b1;

    run_op("mult_neg",   3'b000, 32'hFFFFFFFF, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFB, 33, 1, -1, -1);
    run_op("multu",      3'b001, 32'hFFFFFFFF, 32'h5, 32'h00000004, 32'hFFFFFFFB, 33, 1, -1, -1);
    run_op("mult_min",   3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 33, 1, -1, -1);
    run_op("div_neg",    3'b010, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 1, -1, -1);
    run_op("divu",       3'b011, 32'h7, 32'h2, 32'h1, 32'h3, 33, 1, -1, -1);
    run_op("div_wrap",   3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 33, 1, -1, -1);
    run_op("divu_zero",  3'b011, 32'h7, 32'h0, 32'h7, 32'hFFFFFFFF, 33, 1, -1, -1);
    run_op("div_zero",   3'b010, 32'hFFFFFFF9, 32'h0, 32'hFFFFFFF9, 32'hFFFFFFFF, 33, 1, -1, -1);

    // MTHI then MTLO back to back
    @(negedge clk);
    MdOp = 3'b100; MdOp1 = 32'h1234; MdStart = 1'b1;
    @(negedge clk);
    chk("mthi_hi", 64'(Hi), 64'h1234);
    chk("mthi_busy", 64'(Busy), 64'h0);
    MdOp = 3'b101; MdOp1 = 32'h5678;
    @(negedge clk);
    chk("mtlo_lo", 64'(Lo), 64'h5678);
    chk("mtlo_hi", 64'(Hi), 64'h1234);
    chk("mtlo_busy", 64'(Busy), 64'h0);
    chk("mtlo_done", 64'(Done), 64'h0);
    MdOp = 3'b110; MdOp1 = 32'hAAAA;
    @(negedge clk);
    MdStart = 1'b0;
    chk("nop_busy", 64'(Busy), 64'h0);
    chk("nop_hilo", {Hi, Lo}, {32'h1234, 32'h5678});

    // start while busy is ignored: 3 * -2
    run_op("mult_restart", 3'b000, 32'h3, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, 33, 1, 10, -1);

    // abort mid-divide keeps prior HI/LO, then a clean divide
    run_op("div_abort", 3'b011, 32'd100, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFA, 15, 0, -1, 15);
    run_op("divu_after", 3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 33, 1, -1, -1);

    // abort alongside MTLO drops the write
    @(negedge clk);
    MdOp = 3'b101; MdOp1 = 32'hBEEF; MdStart = 1'b1; MdAbort = 1'b1;
    @(negedge clk);
    MdStart = 1'b0; MdAbort = 1'b0;
    chk("mtlo_abort_lo", 64'(Lo), 64'd14);

    // async reset mid-multiply
    @(negedge clk);
    MdOp = 3'b000; MdOp1 = 32'h7; MdOp2 = 32'h9; MdStart = 1'b1;
    @(negedge clk);
    MdStart = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_busy", 64'(Busy), 64'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_hi", 64'(Hi), 64'h0);
    chk("async_rst_lo", 64'(Lo), 64'h0);
    chk("async_rst_busy", 64'(Busy), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_done", 64'(Done), 64'h0);
    chk("post_rst_busy", 64'(Busy), 64'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
